// File: rtl/fabric_pkg.sv
// fabric_pkg: shared descriptor layout, reset defaults and sequencer state encoding
package fabric_pkg;
  localparam int DEPTH_W  = 16;
  localparam int STRIDE_W = 8;
  localparam int HINTS_W  = 32;
  localparam int LCNT_W   = 16;
  localparam int LMASK_W  = 15;
  localparam logic [LCNT_W-1:0]  DEF_LANE_COUNT = 16'd15;
  localparam logic [LMASK_W-1:0] DEF_LANE_MASK  = 15'h7FFF;
  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_RUN, S_DONE, S_DRAIN} state_t;
  typedef struct packed {
    logic [DEPTH_W-1:0]  depth;
    logic [STRIDE_W-1:0] stride;
    logic [HINTS_W-1:0]  hints;
    logic [LCNT_W-1:0]   lane_count;
    logic [LMASK_W-1:0]  lane_mask;
  } job_cfg_t;
  localparam job_cfg_t CFG_RESET = '{depth: '0, stride: '0, hints: '0, lane_count: DEF_LANE_COUNT, lane_mask: DEF_LANE_MASK};
endpackage

// File: rtl/fabric_job_fifo.sv
// fabric_job_fifo: synchronous descriptor FIFO with occupancy count and flush
module fabric_job_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_flush,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty,
  output logic [AW:0]      o_count
);
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr;
  logic [AW-1:0]    r_rd;
  logic [AW:0]      r_count;
  logic             w_push;
  logic             w_pop;
  assign o_full  = r_count == (AW+1)'(DEPTH);
  assign o_empty = r_count == '0;
  assign o_count = r_count;
  assign o_data  = r_mem[r_rd];
  assign w_push  = i_push && !o_full && !i_flush;
  assign w_pop   = i_pop && !o_empty && !i_flush;
  // descriptor storage, written at the tail
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= i_data;
  end
  // pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk) begin
    if (rst || i_flush) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      r_wr    <= w_push ? r_wr + AW'(1) : r_wr;
      r_rd    <= w_pop ? r_rd + AW'(1) : r_rd;
      r_count <= (w_push && !w_pop) ? r_count + (AW+1)'(1) : (w_pop && !w_push) ? r_count - (AW+1)'(1) : r_count;
    end
  end
endmodule

// File: rtl/fabric_job_sequencer.sv
// fabric_job_sequencer: queues fabric job descriptors and runs them back-to-back with watchdog and abort
module fabric_job_sequencer #(
  parameter int ADDR_WIDTH     = 32,
  parameter int QUEUE_DEPTH    = 4,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                         s_axi_aclk,
  input  logic                         s_axi_areset,
  input  logic                         job_valid,
  output logic                         job_ready,
  input  logic [ADDR_WIDTH-1:0]        job_base_addr,
  input  logic [15:0]                  job_depth,
  input  logic [7:0]                   job_stride,
  input  logic [31:0]                  job_exec_hints,
  input  logic [15:0]                  job_lane_count,
  input  logic [14:0]                  job_lane_mask,
  input  logic                         abort,
  input  logic                         err_clear,
  output logic [ADDR_WIDTH-1:0]        fabric_base_addr,
  output logic [15:0]                  fabric_depth,
  output logic [7:0]                   fabric_stride,
  output logic [31:0]                  fabric_exec_hints,
  output logic [15:0]                  fabric_lane_count,
  output logic [14:0]                  fabric_lane_mask,
  output logic                         fabric_start,
  input  logic                         fabric_done,
  output logic                         busy,
  output logic [$clog2(QUEUE_DEPTH):0] queue_count,
  output logic [31:0]                  jobs_completed,
  output logic                         timeout_err,
  output logic                         irq_done
);
  import fabric_pkg::*;
  localparam int DW = ADDR_WIDTH + $bits(job_cfg_t);
  localparam logic [31:0] WD_LAST = 32'(TIMEOUT_CYCLES - 1);
  state_t                r_state;
  state_t                w_next;
  logic [ADDR_WIDTH-1:0] r_base;
  job_cfg_t              r_cfg;
  logic [31:0]           r_wdog;
  logic [31:0]           r_jobs;
  logic                  r_err;
  logic                  r_irq;
  logic [DW-1:0]         w_head;
  job_cfg_t              w_in_cfg;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_pop;
  logic                  w_fire;
  logic                  w_retire;
  assign w_in_cfg = '{depth: job_depth, stride: job_stride, hints: job_exec_hints, lane_count: job_lane_count, lane_mask: job_lane_mask};
  fabric_job_fifo #(.WIDTH(DW), .DEPTH(QUEUE_DEPTH)) u_fifo (
    .clk     (s_axi_aclk),
    .rst     (s_axi_areset),
    .i_flush (abort),
    .i_push  (job_valid),
    .i_data  ({job_base_addr, w_in_cfg}),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (queue_count)
  );
  assign job_ready         = !w_full;
  assign fabric_base_addr  = r_base;
  assign fabric_depth      = r_cfg.depth;
  assign fabric_stride     = r_cfg.stride;
  assign fabric_exec_hints = r_cfg.hints;
  assign fabric_lane_count = r_cfg.lane_count;
  assign fabric_lane_mask  = r_cfg.lane_mask;
  assign jobs_completed    = r_jobs;
  assign timeout_err       = r_err;
  assign irq_done          = r_irq;
  // next state and outputs; abort overrides every transition, DONE/DRAIN hold while done is still high
  always_comb begin
    w_pop        = r_state == S_IDLE && !w_empty && !abort;
    w_retire     = r_state == S_RUN && fabric_done && !abort;
    w_fire       = TIMEOUT_CYCLES != 0 && r_state == S_RUN && !fabric_done && !abort && r_wdog == WD_LAST;
    fabric_start = r_state == S_RUN;
    busy         = r_state != S_IDLE;
    w_next       = abort ? S_IDLE :
                   r_state == S_IDLE  ? (w_empty ? S_IDLE : S_SETUP) :
                   r_state == S_SETUP ? S_RUN :
                   r_state == S_RUN   ? (fabric_done ? S_DONE : w_fire ? S_DRAIN : S_RUN) :
                   fabric_done ? r_state : S_IDLE;
  end
  // state, active config, watchdog, completion counter and sticky error
  always_ff @(posedge s_axi_aclk) begin
    if (s_axi_areset) begin
      r_state <= S_IDLE;
      r_base  <= '0;
      r_cfg   <= CFG_RESET;
      r_wdog  <= '0;
      r_jobs  <= '0;
      r_err   <= 1'b0;
      r_irq   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_pop) {r_base, r_cfg} <= w_head;
      r_wdog  <= (r_state == S_RUN && !abort) ? r_wdog + 32'd1 : '0;
      if (w_retire) r_jobs <= r_jobs + 32'd1;
      r_irq   <= w_retire;
      r_err   <= w_fire || (r_err && !err_clear);
    end
  end
endmodule

// File: tb/tb_fabric_job_sequencer.sv
// tb_fabric_job_sequencer: directed self-checking bench for the fabric job sequencer
module tb_fabric_job_sequencer;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        job_valid = 1'b0;
  logic        job_ready;
  logic [31:0] job_base_addr = '0;
  logic [15:0] job_depth = '0;
  logic [7:0]  job_stride = '0;
  logic [31:0] job_exec_hints = '0;
  logic [15:0] job_lane_count = '0;
  logic [14:0] job_lane_mask = '0;
  logic        abort = 1'b0;
  logic        err_clear = 1'b0;
  logic [31:0] fabric_base_addr;
  logic [15:0] fabric_depth;
  logic [7:0]  fabric_stride;
  logic [31:0] fabric_exec_hints;
  logic [15:0] fabric_lane_count;
  logic [14:0] fabric_lane_mask;
  logic        fabric_start;
  logic        fabric_done = 1'b0;
  logic        busy;
  logic [2:0]  queue_count;
  logic [31:0] jobs_completed;
  logic        timeout_err;
  logic        irq_done;
  int          errors = 0;
  int          checks = 0;

  fabric_job_sequencer #(.ADDR_WIDTH(32), .QUEUE_DEPTH(4), .TIMEOUT_CYCLES(16)) dut (
    .s_axi_aclk        (clk),
    .s_axi_areset      (rst),
    .job_valid         (job_valid),
    .job_ready         (job_ready),
    .job_base_addr     (job_base_addr),
    .job_depth         (job_depth),
    .job_stride        (job_stride),
    .job_exec_hints    (job_exec_hints),
    .job_lane_count    (job_lane_count),
    .job_lane_mask     (job_lane_mask),
    .abort             (abort),
    .err_clear         (err_clear),
    .fabric_base_addr  (fabric_base_addr),
    .fabric_depth      (fabric_depth),
    .fabric_stride     (fabric_stride),
    .fabric_exec_hints (fabric_exec_hints),
    .fabric_lane_count (fabric_lane_count),
    .fabric_lane_mask  (fabric_lane_mask),
    .fabric_start      (fabric_start),
    .fabric_done       (fabric_done),
    .busy              (busy),
    .queue_count       (queue_count),
    .jobs_completed    (jobs_completed),
    .timeout_err       (timeout_err),
    .irq_done          (irq_done)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic drive(input logic [31:0] base, input logic [15:0] depth, input logic [14:0] mask);
    job_valid      = 1'b1;
    job_base_addr  = base;
    job_depth      = depth;
    job_stride     = base[19:12];
    job_exec_hints = {base[15:0], 16'hBEEF};
    job_lane_count = 16'd8;
    job_lane_mask  = mask;
  endtask

  task automatic push(input logic [31:0] base);
    drive(base, base[27:12], 15'h00FF);
    step(1);
    job_valid = 1'b0;
  endtask

  task automatic wait_start();
    int n = 0;
    while (!fabric_start && n < 20) begin
      step(1);
      n++;
    end
    chk("start_seen", {31'd0, fabric_start}, 32'd1);
  endtask

  task automatic run_job(input logic [31:0] base);
    wait_start();
    chk("job_order", fabric_base_addr, base);
    fabric_done = 1'b1;
    step(1);
    chk("retire_irq", {31'd0, irq_done}, 32'd1);
    fabric_done = 1'b0;
    step(1);
  endtask

  initial begin
    step(2);
    chk("rst_lane_count", {16'd0, fabric_lane_count}, 32'd15);
    chk("rst_lane_mask", {17'd0, fabric_lane_mask}, 32'h7FFF);
    chk("rst_base", fabric_base_addr, 32'd0);
    chk("rst_depth", {16'd0, fabric_depth}, 32'd0);
    chk("rst_start", {31'd0, fabric_start}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_qcount", {29'd0, queue_count}, 32'd0);
    chk("rst_jobs", jobs_completed, 32'd0);
    chk("rst_err", {31'd0, timeout_err}, 32'd0);
    chk("rst_irq", {31'd0, irq_done}, 32'd0);
    chk("rst_ready", {31'd0, job_ready}, 32'd1);
    rst = 1'b0;
    step(1);
    drive(32'h4000, 16'd64, 15'h00FF);
    step(1);
    job_valid = 1'b0;
    chk("t1_qcount_after_push", {29'd0, queue_count}, 32'd1);
    chk("t1_idle_no_start", {31'd0, fabric_start}, 32'd0);
    step(1);
    chk("t1_setup_busy", {31'd0, busy}, 32'd1);
    chk("t1_setup_no_start", {31'd0, fabric_start}, 32'd0);
    chk("t1_base", fabric_base_addr, 32'h4000);
    chk("t1_depth", {16'd0, fabric_depth}, 32'd64);
    chk("t1_mask", {17'd0, fabric_lane_mask}, 32'h00FF);
    chk("t1_lane_count", {16'd0, fabric_lane_count}, 32'd8);
    chk("t1_qcount_popped", {29'd0, queue_count}, 32'd0);
    step(1);
    chk("t1_start_3cyc", {31'd0, fabric_start}, 32'd1);
    fabric_done = 1'b1;
    step(1);
    chk("t1_done_start_low", {31'd0, fabric_start}, 32'd0);
    chk("t1_irq", {31'd0, irq_done}, 32'd1);
    chk("t1_jobs", jobs_completed, 32'd1);
    step(1);
    chk("t1_irq_single", {31'd0, irq_done}, 32'd0);
    chk("t1_busy_held", {31'd0, busy}, 32'd1);
    fabric_done = 1'b0;
    step(1);
    chk("t1_busy_fall", {31'd0, busy}, 32'd0);
    push(32'h1000);
    push(32'h2000);
    chk("t2_push_pop_same", {29'd0, queue_count}, 32'd1);
    push(32'h3000);
    push(32'h4000);
    push(32'h5000);
    chk("t2_full_count", {29'd0, queue_count}, 32'd4);
    chk("t2_ready_low", {31'd0, job_ready}, 32'd0);
    drive(32'h6000, 16'd1, 15'h0001);
    step(2);
    job_valid = 1'b0;
    chk("t2_held_count", {29'd0, queue_count}, 32'd4);
    run_job(32'h1000);
    run_job(32'h2000);
    run_job(32'h3000);
    run_job(32'h4000);
    run_job(32'h5000);
    step(4);
    chk("t2_dropped_push", {31'd0, busy}, 32'd0);
    chk("t2_qcount_empty", {29'd0, queue_count}, 32'd0);
    chk("t2_jobs", jobs_completed, 32'd6);
    push(32'h7000);
    push(32'h8000);
    wait_start();
    chk("t3_base", fabric_base_addr, 32'h7000);
    begin
      int n = 0;
      while (fabric_start && n < 40) begin
        n++;
        step(1);
      end
      chk("t3_run_cycles", n, 32'd16);
    end
    chk("t3_err_set", {31'd0, timeout_err}, 32'd1);
    chk("t3_jobs_same", jobs_completed, 32'd6);
    chk("t3_no_irq", {31'd0, irq_done}, 32'd0);
    run_job(32'h8000);
    chk("t3_jobs_next", jobs_completed, 32'd7);
    chk("t3_err_sticky", {31'd0, timeout_err}, 32'd1);
    err_clear = 1'b1;
    step(1);
    err_clear = 1'b0;
    chk("t3_err_clear", {31'd0, timeout_err}, 32'd0);
    push(32'h9000);
    push(32'hA000);
    push(32'hB000);
    wait_start();
    chk("t4_queued", {29'd0, queue_count}, 32'd2);
    abort = 1'b1;
    drive(32'hF00D, 16'd2, 15'h0002);
    step(1);
    abort = 1'b0;
    job_valid = 1'b0;
    chk("t4_start_low", {31'd0, fabric_start}, 32'd0);
    chk("t4_qcount", {29'd0, queue_count}, 32'd0);
    chk("t4_busy", {31'd0, busy}, 32'd0);
    fabric_done = 1'b1;
    step(1);
    fabric_done = 1'b0;
    chk("t4_done_ignored_irq", {31'd0, irq_done}, 32'd0);
    step(2);
    chk("t4_done_ignored_busy", {31'd0, busy}, 32'd0);
    chk("t4_jobs", jobs_completed, 32'd7);
    push(32'hC000);
    push(32'hD000);
    wait_start();
    chk("t5_base", fabric_base_addr, 32'hC000);
    fabric_done = 1'b1;
    step(1);
    chk("t5_irq", {31'd0, irq_done}, 32'd1);
    step(3);
    chk("t5_hold_no_start", {31'd0, fabric_start}, 32'd0);
    chk("t5_hold_busy", {31'd0, busy}, 32'd1);
    chk("t5_hold_base", fabric_base_addr, 32'hC000);
    chk("t5_hold_queue", {29'd0, queue_count}, 32'd1);
    chk("t5_irq_once", {31'd0, irq_done}, 32'd0);
    fabric_done = 1'b0;
    step(1);
    chk("t5_idle", {31'd0, busy}, 32'd0);
    run_job(32'hD000);
    chk("t5_jobs", jobs_completed, 32'd9);
    push(32'hE000);
    push(32'hF000);
    wait_start();
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    chk("t6_rst_start", {31'd0, fabric_start}, 32'd0);
    chk("t6_rst_queue", {29'd0, queue_count}, 32'd0);
    chk("t6_rst_jobs", jobs_completed, 32'd0);
    chk("t6_rst_base", fabric_base_addr, 32'd0);
    chk("t6_rst_lane_count", {16'd0, fabric_lane_count}, 32'd15);
    step(3);
    chk("t6_rst_stays_idle", {31'd0, busy}, 32'd0);
    force dut.r_jobs = 32'hFFFF_FFFF;
    #1;
    release dut.r_jobs;
    chk("t7_preload", jobs_completed, 32'hFFFF_FFFF);
    push(32'h1234_0000);
    run_job(32'h1234_0000);
    chk("t7_wrap", jobs_completed, 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
